// File: rtl/uart_transceiver.sv
// Full-duplex UART: 16x-oversampled transmitter and receiver
// sharing one runtime baud divisor.
module uart_transceiver #(
  parameter int unsigned MAX_WIDTH     = 32,
  parameter int unsigned NUM_STOP_BITS = 1,
  parameter string       PARITY_MODE   = "EVEN",
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [MAX_WIDTH-1:0]  baud_rate_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_start_i,
  output logic                  tx_o,
  output logic                  tx_done_o,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_parity_error_o,
  output logic                  rx_done_o
);

  localparam bit HAS_PAR = (PARITY_MODE != "NONE");
  localparam bit ODD_PAR = (PARITY_MODE == "ODD");
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);
  localparam logic [1:0] LAST_STOP = 2'(NUM_STOP_BITS - 1);
  localparam logic [MAX_WIDTH-1:0] ONE = MAX_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [MAX_WIDTH-1:0] div;
  assign div = (baud_rate_i == '0) ? ONE : baud_rate_i;

  // ---------------- transmitter ----------------
  state_t tx_state, tx_state_n;
  logic [MAX_WIDTH-1:0] tx_cnt;
  logic [3:0] tx_sub, tx_sub_n;
  logic [IW-1:0] tx_idx, tx_idx_n;
  logic [1:0] tx_stop, tx_stop_n;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic tx_tick, tx_bit_end, tx_par;
  logic tx_line_n, tx_done_n;

  assign tx_tick = (tx_state != S_IDLE) && (tx_cnt == div - ONE);
  assign tx_bit_end = tx_tick && (tx_sub == 4'd15);
  assign tx_par = (^tx_shift) ^ ODD_PAR;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_cnt <= '0;
    end else if (tx_state == S_IDLE || tx_tick) begin
      tx_cnt <= '0;
    end else begin
      tx_cnt <= tx_cnt + ONE;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_sub_n   = tx_sub;
    tx_idx_n   = tx_idx;
    tx_stop_n  = tx_stop;
    tx_done_n  = 1'b0;
    if (tx_tick) tx_sub_n = tx_sub + 4'd1;
    unique case (tx_state)
      S_IDLE: begin
        tx_sub_n  = '0;
        tx_idx_n  = '0;
        tx_stop_n = '0;
        if (tx_start_i) tx_state_n = S_START;
      end
      S_START: begin
        if (tx_bit_end) tx_state_n = S_DATA;
      end
      S_DATA: begin
        if (tx_bit_end) begin
          tx_idx_n = tx_idx + 1'b1;
          if (tx_idx == LAST_IDX)
            tx_state_n = HAS_PAR ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (tx_bit_end) tx_state_n = S_STOP;
      end
      S_STOP: begin
        if (tx_bit_end) begin
          tx_stop_n = tx_stop + 2'd1;
          if (tx_stop == LAST_STOP) begin
            tx_state_n = S_IDLE;
            tx_done_n  = 1'b1;
          end
        end
      end
      default: tx_state_n = S_IDLE;
    endcase
  end

  // line level is registered from the next state so tx_o is glitch-free
  always_comb begin
    tx_line_n = 1'b1;
    unique case (tx_state_n)
      S_START:  tx_line_n = 1'b0;
      S_DATA:   tx_line_n = tx_shift[tx_idx_n];
      S_PARITY: tx_line_n = tx_par;
      default:  tx_line_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state  <= S_IDLE;
      tx_sub    <= '0;
      tx_idx    <= '0;
      tx_stop   <= '0;
      tx_shift  <= '0;
      tx_o      <= 1'b1;
      tx_done_o <= 1'b0;
    end else begin
      tx_state  <= tx_state_n;
      tx_sub    <= tx_sub_n;
      tx_idx    <= tx_idx_n;
      tx_stop   <= tx_stop_n;
      tx_o      <= tx_line_n;
      tx_done_o <= tx_done_n;
      if (tx_state == S_IDLE && tx_start_i) tx_shift <= tx_data_i;
    end
  end

  // ---------------- receiver ----------------
  state_t rx_state, rx_state_n;
  logic [MAX_WIDTH-1:0] rx_cnt;
  logic [3:0] rx_sub, rx_sub_n;
  logic [IW-1:0] rx_idx, rx_idx_n;
  logic [DATA_WIDTH-1:0] rx_shift, rx_shift_n;
  logic rx_meta, rx_sync;
  logic rx_par, rx_par_n;
  logic rx_tick, rx_sample, rx_done_n, rx_perr_n;

  assign rx_tick = (rx_state != S_IDLE) && (rx_cnt == div - ONE);
  assign rx_sample = rx_tick && (rx_sub == 4'd15);
  assign rx_perr_n = HAS_PAR && (rx_par != ((^rx_shift) ^ ODD_PAR));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_cnt  <= '0;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      if (rx_state == S_IDLE || rx_tick) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + ONE;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_sub_n   = rx_sub;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_par_n   = rx_par;
    rx_done_n  = 1'b0;
    if (rx_tick) rx_sub_n = rx_sub + 4'd1;
    unique case (rx_state)
      S_IDLE: begin
        rx_sub_n = '0;
        rx_idx_n = '0;
        if (!rx_sync) rx_state_n = S_START;
      end
      S_START: begin
        // eighth tick lands mid start bit; re-align sampling there
        if (rx_tick && rx_sub == 4'd7) begin
          rx_sub_n   = '0;
          rx_state_n = rx_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_sample) begin
          rx_shift_n = {rx_sync, rx_shift[DATA_WIDTH-1:1]};
          rx_idx_n   = rx_idx + 1'b1;
          if (rx_idx == LAST_IDX)
            rx_state_n = HAS_PAR ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (rx_sample) begin
          rx_par_n   = rx_sync;
          rx_state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_sample) begin
          rx_done_n  = 1'b1;
          rx_state_n = S_IDLE;
        end
      end
      default: rx_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state          <= S_IDLE;
      rx_sub            <= '0;
      rx_idx            <= '0;
      rx_shift          <= '0;
      rx_par            <= 1'b0;
      rx_data_o         <= '0;
      rx_parity_error_o <= 1'b0;
      rx_done_o         <= 1'b0;
    end else begin
      rx_state  <= rx_state_n;
      rx_sub    <= rx_sub_n;
      rx_idx    <= rx_idx_n;
      rx_shift  <= rx_shift_n;
      rx_par    <= rx_par_n;
      rx_done_o <= rx_done_n;
      if (rx_done_n) begin
        rx_data_o         <= rx_shift;
        rx_parity_error_o <= rx_perr_n;
      end
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver: line shape, loopback,
// parity error, glitch rejection and mid-frame reset.
module tb_uart_transceiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] baud = 32'd1;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_start = 1'b0;
  logic        tx_line;
  logic        tx_done;
  logic        rx_drv = 1'b1;
  logic        loop = 1'b0;
  logic        rx_line;
  logic [7:0]  rx_data;
  logic        rx_perr;
  logic        rx_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int c0 = 0;
  int ntx = 0;
  int nrx = 0;

  assign rx_line = loop ? tx_line : rx_drv;

  uart_transceiver dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .baud_rate_i       (baud),
    .tx_data_i         (tx_data),
    .tx_start_i        (tx_start),
    .tx_o              (tx_line),
    .tx_done_o         (tx_done),
    .rx_i              (rx_line),
    .rx_data_o         (rx_data),
    .rx_parity_error_o (rx_perr),
    .rx_done_o         (rx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_done) ntx <= ntx + 1;
    if (rx_done) nrx <= nrx + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'hFF;
    c0 = cyc;
  endtask

  task automatic wait_tx(output int len);
    len = -1;
    for (int n = 0; n < 20000; n++) begin
      if (tx_done) begin
        len = cyc - c0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic p,
                          input int b);
    logic [10:0] f;
    f = {1'b1, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_drv = f[i];
      repeat (16 * b) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (16 * b) @(negedge clk);
  endtask

  initial begin
    logic [10:0] line_exp;
    int len;
    int snap_tx;
    int snap_rx;

    repeat (3) @(negedge clk);
    check("rst_tx", tx_line, 1);
    check("rst_tx_done", tx_done, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_perr", rx_perr, 0);
    check("rst_rx_done", rx_done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // line shape at baud=1, data 0x01, even parity
    line_exp = 11'b11000000010;
    send(8'h01);
    for (int k = 0; k < 176; k++) begin
      check("line", {tx_done, tx_line}, {1'b0, line_exp[k / 16]});
      @(negedge clk);
    end
    check("line_end", {tx_done, tx_line}, 2'b11);
    @(negedge clk);
    check("done_pulse", tx_done, 0);
    repeat (4) @(negedge clk);

    // loopback at baud=66
    baud = 32'd66;
    loop = 1'b1;
    snap_tx = ntx;
    snap_rx = nrx;
    send(8'hA5);
    wait_tx(len);
    check("lb_len", len, 11616);
    repeat (2) @(negedge clk);
    check("lb_data", rx_data, 8'hA5);
    check("lb_perr", rx_perr, 0);
    check("lb_rx_cnt", nrx - snap_rx, 1);
    check("lb_tx_cnt", ntx - snap_tx, 1);

    // back-to-back second byte
    snap_tx = ntx;
    snap_rx = nrx;
    send(8'h3C);
    wait_tx(len);
    check("b2b_len", len, 11616);
    repeat (2) @(negedge clk);
    check("b2b_data", rx_data, 8'h3C);
    check("b2b_perr", rx_perr, 0);
    check("b2b_rx_cnt", nrx - snap_rx, 1);
    check("b2b_tx_cnt", ntx - snap_tx, 1);

    // externally driven frames at baud=2
    loop = 1'b0;
    baud = 32'd2;
    repeat (4) @(negedge clk);
    snap_rx = nrx;
    drive_rx(8'h5A, 1'b1, 2);
    check("bad_par_data", rx_data, 8'h5A);
    check("bad_par_flag", rx_perr, 1);
    check("bad_par_cnt", nrx - snap_rx, 1);
    drive_rx(8'h07, 1'b1, 2);
    check("good_par_data", rx_data, 8'h07);
    check("good_par_flag", rx_perr, 0);
    check("good_par_cnt", nrx - snap_rx, 2);

    // 3-clock glitch at baud=66 must be rejected
    baud = 32'd66;
    snap_rx = nrx;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * 16 * 66) @(negedge clk);
    check("glitch_cnt", nrx - snap_rx, 0);
    check("glitch_data", rx_data, 8'h07);
    baud = 32'd2;
    drive_rx(8'hC3, 1'b0, 2);
    check("after_glitch_data", rx_data, 8'hC3);
    check("after_glitch_perr", rx_perr, 0);
    check("after_glitch_cnt", nrx - snap_rx, 1);

    // reset in the middle of a TX frame
    baud = 32'd4;
    snap_tx = ntx;
    send(8'hFF);
    repeat (20) @(negedge clk);
    check("mid_start_bit", tx_line, 0);
    rst_n = 1'b0;
    #1;
    check("rst_abort_tx", tx_line, 1);
    check("rst_abort_done", tx_done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (800) @(negedge clk);
    check("rst_no_done", ntx - snap_tx, 0);
    check("rst_rx_cleared", rx_data, 0);

    loop = 1'b1;
    snap_tx = ntx;
    send(8'h96);
    wait_tx(len);
    check("post_rst_len", len, 704);
    repeat (2) @(negedge clk);
    check("post_rst_data", rx_data, 8'h96);
    check("post_rst_perr", rx_perr, 0);
    check("post_rst_tx_cnt", ntx - snap_tx, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
